// File: rtl/bus_req_demux_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_req_demux_if
// Description : Bundle of the CPU-side request/response signals and the
//               two-slave side signals around bus_req_demux.
//               master modport : environment view (CPU plus both slaves)
//               slave modport  : demultiplexer view
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_req_demux_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // CPU side
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;
  // Slave side
  logic              s0_req;
  logic              s1_req;
  logic              s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s0_ack;
  logic              s1_ack;
  logic [DATA_W-1:0] s0_rdata;
  logic [DATA_W-1:0] s1_rdata;

  modport master (
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata, m_err,
    input  s0_req, s1_req, s_we, s_addr, s_wdata,
    output s0_ack, s1_ack, s0_rdata, s1_rdata
  );

  modport slave (
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata, m_err,
    output s0_req, s1_req, s_we, s_addr, s_wdata,
    input  s0_ack, s1_ack, s0_rdata, s1_rdata
  );
endinterface
`default_nettype wire

// File: rtl/bus_req_demux.sv
`default_nettype none
// ============================================================================
// Module      : bus_req_demux
// Description : Routes a single outstanding CPU data-bus request to data RAM
//               (slave 0) or the MMIO window (slave 1) by address decode and
//               returns the completion, with a per-transaction timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_req_demux #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] S1_BASE = 32'hFFFF0000,
  parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF0000,
  parameter int                TIMEOUT = 16
) (
  input  wire logic    clk,
  input  wire logic    rst,
  bus_req_demux_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Last BUSY count value before the timeout fires
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q;
  logic [15:0]       cnt_q;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ready_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              s0_req_q;
  logic              s1_req_q;

  logic              sel_d;
  logic [15:0]       cnt_d;
  logic              ack_d;
  logic [DATA_W-1:0] rdata_d;

  // Address decode of the incoming request and selection of the live slave
  always_comb begin
    sel_d   = ((bus.m_addr & S1_MASK) == S1_BASE);
    cnt_d   = cnt_q + 16'd1;
    ack_d   = sel_q ? bus.s1_ack : bus.s0_ack;
    rdata_d = we_q ? '0 : (sel_q ? bus.s1_rdata : bus.s0_rdata);
  end

  // Transaction FSM with registered request/response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      s0_req_q <= 1'b0;
      s1_req_q <= 1'b0;
    end else begin
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Slave acks here belong to no transaction and are ignored
          if (bus.m_req) begin
            we_q     <= bus.m_we;
            addr_q   <= bus.m_addr;
            wdata_q  <= bus.m_wdata;
            sel_q    <= sel_d;
            ready_q  <= 1'b1;
            s0_req_q <= ~sel_d;
            s1_req_q <= sel_d;
            cnt_q    <= '0;
            state_q  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack is checked before the timeout so a last-cycle ack still wins
          if (ack_d) begin
            s0_req_q <= 1'b0;
            s1_req_q <= 1'b0;
            rdata_q  <= rdata_d;
            err_q    <= 1'b0;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end else if (cnt_q == TMO_LAST) begin
            s0_req_q <= 1'b0;
            s1_req_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b1;
            rvalid_q <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          // rdata/err stay put until the next completion
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_ready  = ready_q;
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_rdata  = rdata_q;
  assign bus.m_err    = err_q;
  assign bus.s0_req   = s0_req_q;
  assign bus.s1_req   = s1_req_q;
  assign bus.s_we     = we_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;

endmodule
`default_nettype wire
